// File: rtl/fifo_stream_pkg.sv
// fifo_stream_pkg: shared state type and output buffer sizing for fifo_stream_reader
package fifo_stream_pkg;
  typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;
  localparam int BUF_DEPTH = 2;
  localparam int CNT_W = $clog2(BUF_DEPTH + 1);
endpackage

// File: rtl/fifo_stream_skid.sv
// fifo_stream_skid: 2-entry output buffer; upstream must never push into a full buffer
module fifo_stream_skid
  import fifo_stream_pkg::*;
#(
  parameter int DW = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [DW-1:0]    in_data,
  output logic             valid,
  input  logic             ready,
  output logic [DW-1:0]    data,
  output logic [CNT_W-1:0] count
);
  logic [DW-1:0]    b0, b1;
  logic             pop;
  logic [CNT_W-1:0] slot;
  assign valid = count != '0;
  assign data  = b0;
  assign pop   = valid && ready;
  // slot the incoming word lands in, after this cycle's pop has shifted the head
  assign slot  = count - CNT_W'(pop);
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      b0    <= '0;
      b1    <= '0;
      count <= '0;
    end else begin
      if (pop && count == CNT_W'(BUF_DEPTH)) b0 <= b1;
      if (in_valid && slot == CNT_W'(0)) b0 <= in_data;
      if (in_valid && slot == CNT_W'(1)) b1 <= in_data;
      count <= count + CNT_W'(in_valid) - CNT_W'(pop);
    end
endmodule

// File: rtl/fifo_stream_reader.sv
// fifo_stream_reader: reads len words from a FIFO and emits them as a valid/ready stream
// Optional transfer counter output xfer_cnt enabled by FIFO_STREAM_READER_STAT_EN.
module fifo_stream_reader
  import fifo_stream_pkg::*;
#(
  parameter int DW = 8,
  parameter int LW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [LW-1:0] len,
  output logic          busy,
  output logic          done,
  output logic          fifo_read,
  input  logic          fifo_empty,
  input  logic [DW-1:0] fifo_dout,
  output logic [DW-1:0] m_data,
  output logic          m_valid,
  input  logic          m_ready,
  output logic          m_last
`ifdef FIFO_STREAM_READER_STAT_EN
  ,
  output logic [31:0]   xfer_cnt
`endif
);
  state_t           state;
  logic [LW-1:0]    rem, len_q, sent;
  logic             inflight, pop;
  logic [CNT_W-1:0] count;
  logic [CNT_W:0]   occ_after;
  assign pop       = m_valid && m_ready;
  // words held or in flight once this cycle's transfer has left
  assign occ_after = (CNT_W+1)'(count) + (CNT_W+1)'(inflight) - (CNT_W+1)'(pop);
  assign fifo_read = state == RUN && !fifo_empty && rem != '0 && occ_after < (CNT_W+1)'(BUF_DEPTH);
  assign busy      = state == RUN || state == FLUSH;
  assign done      = state == DONE;
  assign m_last    = m_valid && sent == len_q - LW'(1);
  fifo_stream_skid #(.DW(DW)) u_skid (
    .clk      (clk),
    .rst      (rst),
    .in_valid (inflight),
    .in_data  (fifo_dout),
    .valid    (m_valid),
    .ready    (m_ready),
    .data     (m_data),
    .count    (count)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state    <= IDLE;
      rem      <= '0;
      len_q    <= '0;
      sent     <= '0;
      inflight <= 1'b0;
    end else begin
      inflight <= fifo_read;
      if (pop) sent <= sent + LW'(1);
      case (state)
        IDLE: if (start) begin
          len_q <= len;
          rem   <= len;
          sent  <= '0;
          state <= len != '0 ? RUN : DONE;
        end
        RUN: if (fifo_read) begin
          rem <= rem - LW'(1);
          if (rem == LW'(1)) state <= FLUSH;
        end
        FLUSH: if (!inflight && occ_after == '0) state <= DONE;
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
`ifdef FIFO_STREAM_READER_STAT_EN
  always_ff @(posedge clk or posedge rst)
    if (rst) xfer_cnt <= '0;
    else if (pop) xfer_cnt <= xfer_cnt + 32'd1;
`endif
endmodule

// File: tb/tb_fifo_stream_reader.sv
// tb_fifo_stream_reader: table-driven bursts against a FIFO model plus reset/zero-length sequences
module tb_fifo_stream_reader;
  localparam int DW = 8;
  localparam int LW = 16;
  logic clk = 1'b0;
  logic rst, start, busy, done, fifo_read, fifo_empty, m_valid, m_ready, m_last, gap;
  logic [LW-1:0] len;
  logic [DW-1:0] fifo_dout, m_data;
`ifdef FIFO_STREAM_READER_STAT_EN
  logic [31:0] xfer_cnt;
`endif
  always #5 clk = ~clk;
  fifo_stream_reader #(.DW(DW), .LW(LW)) dut (
    .clk(clk), .rst(rst), .start(start), .len(len), .busy(busy), .done(done),
    .fifo_read(fifo_read), .fifo_empty(fifo_empty), .fifo_dout(fifo_dout),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .m_last(m_last)
`ifdef FIFO_STREAM_READER_STAT_EN
    , .xfer_cnt(xfer_cnt)
`endif
  );
  logic [DW-1:0] mem [0:255];
  int wp, rp;
  assign fifo_empty = rp >= wp || gap;
  always @(posedge clk) if (fifo_read) begin
    fifo_dout <= mem[rp % 256];
    rp <= rp + 1;
  end
  logic [DW-1:0] got [0:511];
  bit lastv [0:511];
  int xc [0:511];
  int cyc, ngot, nreads, ndone, dc, stab_err, occ_err, rd_err, outst;
  logic pv, pr;
  logic [DW-1:0] pd;
  always @(negedge clk) begin
    cyc++;
    if (rst) outst = 0;
    else begin
      if (m_valid && m_ready && ngot < 512) begin
        got[ngot] = m_data; lastv[ngot] = m_last; xc[ngot] = cyc; ngot++;
      end
      if (pv && !pr && (!m_valid || m_data != pd)) stab_err++;
      if (fifo_read) begin nreads++; if (fifo_empty) rd_err++; end
      outst = outst + int'(fifo_read) - int'(m_valid && m_ready);
      if (outst > 2) occ_err++;
      if (done) begin ndone++; dc = cyc; end
    end
    pv = m_valid; pr = m_ready; pd = m_data;
  end
  int n_chk, n_fail;
  task automatic chk(input string nm, input longint act, input longint exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask
  function automatic logic [DW-1:0] pat(input int k);
    return DW'(k * 7 + 3);
  endfunction
  typedef struct {int len; int mode; int gap_at; int gap_len; int fill; int exp_words; int exp_remain;} vec_t;
  task automatic run_burst(input vec_t v);
    int g0, r0, d0, se0, oe0, re0, c, nbad, nlast, lpos;
    wp = rp + v.fill;
    r0 = rp; g0 = ngot; d0 = ndone; se0 = stab_err; oe0 = occ_err; re0 = rd_err;
    m_ready = 1'b1;
    start = 1'b1; len = LW'(v.len);
    @(posedge clk); #1 start = 1'b0;
    c = 0;
    while (ndone == d0 && c < 300) begin
      m_ready = v.mode != 0 ? (c % 3 == 0) : 1'b1;
      gap = c >= v.gap_at && c < v.gap_at + v.gap_len;
      @(posedge clk); #1 c++;
    end
    m_ready = 1'b1; gap = 1'b0;
    @(posedge clk); #1;
    chk("done_seen", ndone - d0, 1);
    chk("word_count", ngot - g0, v.exp_words);
    nbad = 0; nlast = 0; lpos = -1;
    for (int i = 0; i < ngot - g0; i++) begin
      if (got[g0 + i] != pat(r0 + i)) nbad++;
      if (lastv[g0 + i]) begin nlast++; if (lpos < 0) lpos = i; end
    end
    chk("data_order", nbad, 0);
    chk("last_count", nlast, 1);
    chk("last_pos", lpos, v.exp_words - 1);
    chk("fifo_remain", wp - rp, v.exp_remain);
    if (ngot > g0) begin
      chk("done_latency", dc - xc[ngot - 1], 1);
      if (v.mode == 0 && v.gap_len == 0) chk("back_to_back", xc[ngot - 1] - xc[g0], v.exp_words - 1);
    end
    chk("stall_stable", stab_err - se0, 0);
    chk("outstanding", occ_err - oe0, 0);
    chk("read_on_empty", rd_err - re0, 0);
    chk("idle_busy", busy, 0);
  endtask
  vec_t vt [4];
  initial begin
    int g0, r0, c;
    vt[0] = '{4, 0, 0, 0, 10, 4, 6};
    vt[1] = '{5, 1, 0, 0, 8, 5, 3};
    vt[2] = '{6, 0, 3, 7, 6, 6, 0};
    vt[3] = '{1, 0, 0, 0, 3, 1, 2};
    for (int k = 0; k < 256; k++) mem[k] = pat(k);
    rst = 1'b1; start = 1'b0; len = '0; m_ready = 1'b1; gap = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", {busy, done, fifo_read, m_valid, m_last, m_data}, 0);
`ifdef FIFO_STREAM_READER_STAT_EN
    chk("reset_xfer_cnt", xfer_cnt, 0);
`endif
    rst = 1'b0;
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) begin
      run_burst(vt[i]);
`ifdef FIFO_STREAM_READER_STAT_EN
      if (i == 1) chk("xfer_cnt", xfer_cnt, 9);
`endif
    end
    // zero-length burst
    r0 = nreads;
    start = 1'b1; len = '0;
    chk("zero_busy_before", busy, 0);
    @(posedge clk); #1 start = 1'b0;
    chk("zero_done", done, 1);
    chk("zero_busy", busy, 0);
    @(posedge clk); #1;
    chk("zero_done_clear", done, 0);
    chk("zero_no_read", nreads - r0, 0);
    // abort after two words, then a fresh burst
    wp = rp + 20; g0 = ngot;
    start = 1'b1; len = LW'(8);
    @(posedge clk); #1 start = 1'b0;
    c = 0;
    while (ngot - g0 < 2 && c < 60) begin @(posedge clk); #1 c++; end
    chk("abort_progress", ngot - g0 >= 2, 1);
    #2 rst = 1'b1;
    #1 chk("abort_outputs", {busy, done, fifo_read, m_valid, m_last, m_data}, 0);
    @(posedge clk); @(posedge clk); #3 rst = 1'b0;
    @(posedge clk); #1;
    run_burst('{3, 0, 0, 0, 5, 3, 2});
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/fifo_stream_reader.md
FIFO_STREAM_READER -- requirements
Module: fifo_stream_reader

Interface
REQ-001 SHALL have parameter DW, default 8, meaning FIFO and stream data width in bits.
REQ-002 SHALL have parameter LW, default 16, meaning burst-length field width.
REQ-003 SHALL have port clk  in  1  single clock; all logic on its rising edge.
REQ-004 SHALL have port rst  in  1  asynchronous, active-high reset.
REQ-005 SHALL have ports start  in  1  burst request pulse; len  in  LW  words to read, sampled with start.
REQ-006 SHALL have ports busy  out  1  burst in progress; done  out  1  one-cycle pulse at burst end.
REQ-007 SHALL have ports fifo_read  out  1  FIFO read strobe; fifo_empty  in  1  FIFO empty; fifo_dout  in  DW  FIFO data, valid one cycle after fifo_read.
REQ-008 SHALL have ports m_data  out  DW; m_valid  out  1; m_ready  in  1; m_last  out  1 (high with the burst's final word).

Function
REQ-009 SHALL use states IDLE, RUN, FLUSH, DONE.
REQ-010 SHALL, in IDLE with start=1 and len!=0, latch len into a remaining-to-issue counter and go to RUN; SHALL ignore start while busy.
REQ-011 SHALL, on start with len=0, go to DONE without asserting fifo_read.
REQ-012 SHALL assert fifo_read combinationally iff state==RUN, fifo_empty=0, issue count remaining !=0, and (buffered words + in-flight reads) < 2 after this cycle's output transfer.
REQ-013 SHALL capture fifo_dout into a 2-entry output buffer exactly one cycle after each fifo_read; no word is ever dropped or duplicated.
REQ-014 SHALL go RUN->FLUSH in the cycle the last read issues; FLUSH->DONE when the buffer is empty and no read is in flight; DONE->IDLE after one cycle.
REQ-015 SHALL assert done only in DONE; busy=1 in RUN and FLUSH.
REQ-016 SHALL keep m_valid and m_data stable while m_valid=1 and m_ready=0; transfer occurs when both are high.
REQ-017 SHALL assert m_last with the word whose index equals len-1, counting from 0.
REQ-018 SHALL sustain one word per cycle when m_ready=1 continuously and the FIFO is non-empty.
REQ-019 SHALL treat fifo_empty=1 mid-burst as a stall only; RUN is held and issuing resumes when data arrives.
REQ-020 SHALL accept len up to 2**LW-1; counters are LW bits and never wrap within a burst.

Reset
REQ-021 SHALL, on rst, asynchronously force state IDLE, counters 0, buffer empty, and in-flight flag 0.
REQ-022 SHALL, while rst is high, drive busy, done, fifo_read, m_valid, and m_last to 0 and m_data to 0.
REQ-023 SHALL discard a burst aborted by rst mid-operation; words already read from the FIFO are lost, and the next start begins a fresh burst.

Configuration
REQ-024 SHALL, with macro FIFO_STREAM_READER_STAT_EN defined, add output xfer_cnt (32 bits), which counts stream transfers, wraps modulo 2**32, and is cleared by rst only.
REQ-025 SHALL, without FIFO_STREAM_READER_STAT_EN, omit the xfer_cnt port and its logic; all other behaviour is identical.

Structure
REQ-026 SHALL place the state enum type (IDLE/RUN/FLUSH/DONE) and the buffer depth constant (2) in shared package fifo_stream_pkg.
REQ-027 SHALL implement the 2-entry output buffer as sub-module fifo_stream_skid, with parameter DW and ports in_valid/in_data and valid/ready/data out, plus a count output.

Verification
REQ-028 Scenario: DW=8; FIFO pre-loaded with 10 words; start, len=4, m_ready=1 -> 4 words on consecutive cycles after the 2-cycle fill; m_last on word 3; done one cycle after the last transfer; 6 words remain in the FIFO.
REQ-029 Scenario: start, len=0 -> done pulse next cycle; fifo_read never asserted; busy stays 0.
REQ-030 Scenario: len=5, m_ready toggling 1,0,0,1,... -> no loss or duplication; m_data stable while stalled; at most 2 reads outstanding plus buffered.
REQ-031 Scenario: FIFO empty for 7 cycles mid-burst (len=6) -> fifo_read low during the gap; burst completes with 6 words in order; m_last on word 5.
REQ-032 Scenario: rst asserted during RUN after 2 of 8 words -> all outputs 0 immediately; a subsequent start with len=3 yields exactly 3 words with m_last on the third.
REQ-033 Scenario: with FIFO_STREAM_READER_STAT_EN defined, bursts of len 4 and then len 5 -> xfer_cnt=9.
